// File: rtl/playback_ctrl.sv
// Playback sequencer for a sample FIFO.
// Tracks a shadow copy of the FIFO occupancy, walks IDLE -> PREFILL -> PLAY,
// issues one FIFO read pulse per sample period while playing, throttles the
// upstream source with watermark hysteresis and keeps sticky error status.
// Every output comes straight from a flop; inputs only reach outputs through
// a clock edge.
module playback_ctrl #(
  parameter int CLK_DIV     = 1125,
  parameter int DEPTH       = 256,
  parameter int START_LEVEL = 128,
  parameter int HIGH_WM     = 224,
  parameter int LOW_WM      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr_stb,
  input  logic        clr_flags,
  output logic        sample_tick,
  output logic        src_ready,
  output logic [8:0]  level,
  output logic [1:0]  state,
  output logic        overflow,
  output logic [15:0] underrun_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    PLAY    = 2'd2
  } state_t;

  // Parameters narrowed once to the widths they are compared against.
  localparam logic [8:0]  DEPTH_L   = 9'(DEPTH);
  localparam logic [8:0]  START_L   = 9'(START_LEVEL);
  localparam logic [8:0]  HIGH_L    = 9'(HIGH_WM);
  localparam logic [8:0]  LOW_L     = 9'(LOW_WM);
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] UCNT_MAX  = 16'hFFFF;

  state_t      state_q;
  logic [15:0] div_q;

  logic wr_acc;       // write the FIFO will actually take
  logic ovf_ev;       // write strobe that hits a full FIFO
  logic term_cnt;     // end of a sample period while playing and enabled
  logic tick_ev;      // terminal count with data available
  logic underrun_ev;  // terminal count with nothing to play

  assign wr_acc      = wr_stb && (level < DEPTH_L);
  assign ovf_ev      = wr_stb && (level == DEPTH_L);
  // enable=0 overrides everything, so a period ending as playback is
  // disabled neither ticks nor counts as an underrun.
  assign term_cnt    = (state_q == PLAY) && enable && (div_q == DIV_LAST);
  assign tick_ev     = term_cnt && (level != 9'd0);
  assign underrun_ev = term_cnt && (level == 9'd0);

  assign state = state_q;

  // Shadow occupancy: +1 on an accepted write, -1 on a read pulse, both cancel.
  // NOTE: rst is sampled only on the clock edge (synchronous), and all
  // sequential state uses non-blocking assignments so every flop sees the
  // pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 9'd0;
    end else begin
      unique case ({wr_acc, sample_tick})
        2'b10:   level <= level + 9'd1;
        2'b01:   level <= level - 9'd1;
        default: level <= level;
      endcase
    end
  end

  // Playback FSM with its sample-period divider and the registered read pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= 16'd0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= 1'b0;
      div_q       <= 16'd0;
      if (!enable) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: state_q <= PREFILL;
          PREFILL: begin
            if (level >= START_L) state_q <= PLAY;
          end
          PLAY: begin
            if (underrun_ev) begin
              state_q <= PREFILL;
            end else begin
              div_q       <= (div_q == DIV_LAST) ? 16'd0 : div_q + 16'd1;
              sample_tick <= tick_ev;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Upstream flow control with hysteresis between the two watermarks.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_ready <= 1'b1;
    end else if (level >= HIGH_L) begin
      src_ready <= 1'b0;
    end else if (level <= LOW_L) begin
      src_ready <= 1'b1;
    end
  end

  // Sticky status; an event in the same cycle as clr_flags survives the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow     <= 1'b0;
      underrun_cnt <= 16'd0;
    end else begin
      if (ovf_ev)         overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;

      if (clr_flags) begin
        underrun_cnt <= underrun_ev ? 16'd1 : 16'd0;
      end else if (underrun_ev && (underrun_cnt != UCNT_MAX)) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_playback_ctrl.sv
// Bench for playback_ctrl: directed scenarios followed by random traffic.
// A reference model predicts the outputs after every clock edge; predictions
// are queued and a separate monitor compares them against the DUT.
module tb_playback_ctrl;

  localparam int CLK_DIV     = 4;
  localparam int DEPTH       = 8;
  localparam int START_LEVEL = 4;
  localparam int HIGH_WM     = 6;
  localparam int LOW_WM      = 2;

  localparam int S_IDLE    = 0;
  localparam int S_PREFILL = 1;
  localparam int S_PLAY    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr_stb = 1'b0;
  logic        clr_flags = 1'b0;
  logic        sample_tick;
  logic        src_ready;
  logic [8:0]  level;
  logic [1:0]  state;
  logic        overflow;
  logic [15:0] underrun_cnt;

  playback_ctrl #(
    .CLK_DIV(CLK_DIV), .DEPTH(DEPTH), .START_LEVEL(START_LEVEL),
    .HIGH_WM(HIGH_WM), .LOW_WM(LOW_WM)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr_stb(wr_stb),
    .clr_flags(clr_flags), .sample_tick(sample_tick), .src_ready(src_ready),
    .level(level), .state(state), .overflow(overflow),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  // Observable behaviour after one clock edge. play_age counts cycles spent
  // in PLAY since entering it; a sample period ends every CLK_DIV-th cycle.
  typedef struct {
    int state;
    int level;
    int play_age;
    int ucnt;
    bit tick;
    bit rdy;
    bit ovf;
  } model_t;

  model_t exp_q[$];
  model_t cur;
  model_t pending;
  bit     have_pending = 1'b0;

  int checks = 0;
  int passed = 0;

  function automatic model_t step(model_t m, bit r, bit en, bit wr, bit clr);
    model_t n;
    bit     period_end;
    bit     starved;
    int     writes;
    if (r) begin
      n.state = S_IDLE; n.level = 0; n.play_age = 0; n.ucnt = 0;
      n.tick = 0; n.rdy = 1; n.ovf = 0;
      return n;
    end
    n = m;
    // A full FIFO drops the write; the read pulse always removes one sample.
    writes  = (wr && m.level < DEPTH) ? 1 : 0;
    n.level = m.level + writes - (m.tick ? 1 : 0);

    period_end = (m.state == S_PLAY) && en && (m.play_age % CLK_DIV == CLK_DIV - 1);
    starved    = period_end && (m.level == 0);
    n.tick     = period_end && (m.level > 0);

    if (!en)                                               n.state = S_IDLE;
    else if (m.state == S_IDLE)                            n.state = S_PREFILL;
    else if (m.state == S_PREFILL && m.level >= START_LEVEL) n.state = S_PLAY;
    else if (starved)                                      n.state = S_PREFILL;

    n.play_age = (m.state == S_PLAY && n.state == S_PLAY) ? m.play_age + 1 : 0;

    if (m.level >= HIGH_WM)     n.rdy = 0;
    else if (m.level <= LOW_WM) n.rdy = 1;

    if (wr && m.level == DEPTH) n.ovf = 1;
    else if (clr)               n.ovf = 0;

    if (clr)                         n.ucnt = starved ? 1 : 0;
    else if (starved && m.ucnt < 65535) n.ucnt = m.ucnt + 1;
    return n;
  endfunction

  // One clock cycle of stimulus. wr_on_tick adds a write exactly in the
  // cycle the DUT is expected to be pulsing sample_tick.
  task automatic cycle(input bit r, input bit en, input bit wr, input bit clr,
                       input bit wr_on_tick = 1'b0);
    bit w;
    @(posedge clk);
    #1;
    if (have_pending) begin
      exp_q.push_back(pending);
      cur = pending;
    end
    w         = wr | (wr_on_tick & cur.tick);
    rst       = r;
    enable    = en;
    wr_stb    = w;
    clr_flags = clr;
    pending      = step(cur, r, en, w, clr);
    have_pending = 1'b1;
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) cycle(1'b0, en, 1'b0, 1'b0);
  endtask

  // Monitor: compares every queued prediction against the DUT mid-cycle.
  initial begin
    model_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (sample_tick !== e.tick || src_ready !== e.rdy ||
            level !== 9'(e.level) || state !== 2'(e.state) ||
            overflow !== e.ovf || underrun_cnt !== 16'(e.ucnt)) begin
          $display("FAIL outputs @%0t: got tick=%b rdy=%b level=%0d state=%0d ovf=%b ucnt=%0d, want tick=%b rdy=%b level=%0d state=%0d ovf=%b ucnt=%0d",
                   $time, sample_tick, src_ready, level, state, overflow, underrun_cnt,
                   e.tick, e.rdy, e.level, e.state, e.ovf, e.ucnt);
        end else begin
          passed++;
        end
      end
    end
  end

  initial begin
    bit en_r;
    int wr_div;

    cur = '{default: 0};
    // Reset state.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Prefill then play until starved: ticks every CLK_DIV, then underrun.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    idle(30, 1'b1);

    // Fill in IDLE past full: overflow, watermark drop, then clear.
    idle(2, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);

    // Drain from full through the hysteresis band and into underrun.
    idle(45, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Writes coincident with ticks at level 5, then at full.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-PLAY with level 5, divider partway through a period.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    idle(3, 1'b0);

    // Random traffic with a slowly varying write rate.
    en_r   = 1'b1;
    wr_div = 2;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) wr_div = $urandom_range(1, 7);
      if ($urandom_range(0, 79) == 0) en_r = ~en_r;
      cycle($urandom_range(0, 299) == 0, en_r,
            $urandom_range(0, wr_div) == 0, $urandom_range(0, 39) == 0);
    end

    // Flush the last prediction and confirm nothing was left unchecked.
    idle(1, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    else
      passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
